tile_bram_read_arbiter: RTL and testbench



---
 rtl/tile_arb_pkg.sv | 32 +++
 rtl/tile_bram_read_arbiter_rr_arbiter.sv | 45 ++++
 rtl/tile_bram_read_arbiter.sv | 115 +++++++++++
 tb/tb_tile_bram_read_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_arb_pkg.sv
// ---------------------------------------------------------------------------
// tile_arb_pkg
// Shared types and constants for the tile BRAM read arbiter.
//   N_REQ_MAX       largest supported requester count
//   RD_LATENCY_MAX  largest supported BRAM read latency
//   req_id_t        requester index, sized for N_REQ_MAX so every
//                   configuration shares one tag layout
//   tag_t           one tag-pipeline stage {vld, id}
//   next_ptr()      modulo-n increment of a requester index
// ---------------------------------------------------------------------------
package tile_arb_pkg;

  localparam int N_REQ_MAX      = 8;
  localparam int RD_LATENCY_MAX = 3;
  localparam int ID_W           = $clog2(N_REQ_MAX);

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } tag_t;

  // Wraps at n-1 so a non-power-of-2 requester count never yields index n.
  function automatic req_id_t next_ptr(input req_id_t cur, input int n);
    if (int'(cur) >= n - 1) begin
      return '0;
    end
    return cur + req_id_t'(1);
  endfunction

endpackage

// File: rtl/tile_bram_read_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set request scanning from ptr_i
// upward, wrapping to index 0.
//   req_i  per-requester request vector
//   ptr_i  index with the highest priority this cycle (always < N_REQ)
//   gnt_o  one-hot grant
//   idx_o  index of the granted requester, 0 when nothing is granted
//   any_o  a grant was made
// ---------------------------------------------------------------------------
module rr_arbiter
  import tile_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_i,
  input  req_id_t          ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output req_id_t          idx_o,
  output logic             any_o
);

  // Two passes replace a modulo scan: first only indices at or above the
  // pointer, then (if nothing hit) everything from 0, which covers the wrap.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_o && req_i[k] && (k >= int'(ptr_i))) begin
        any_o    = 1'b1;
        idx_o    = req_id_t'(k);
        gnt_o[k] = 1'b1;
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        idx_o    = req_id_t'(k);
        gnt_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_bram_read_arbiter.sv
// ---------------------------------------------------------------------------
// tile_bram_read_arbiter
// Shares the single BRAM read port between N_REQ tile readers. One request
// is granted per cycle in round-robin order; a tag pipeline as deep as the
// BRAM read latency steers each returned word back to its requester.
//   out_stream_aclk  clock, all logic on the rising edge
//   periph_resetn    synchronous active-low reset
//   req_valid        per-requester read request
//   req_addr         packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready        one-hot grant, same cycle the request is accepted
//   rsp_valid        one-hot owner of rsp_data this cycle
//   rsp_data         read word broadcast to all requesters
//   bram_en          BRAM read enable
//   bram_addr        BRAM read address
//   bram_rdata       BRAM read data
//   grant_id         index of the current grant, 0 when idle
// ---------------------------------------------------------------------------
module tile_bram_read_arbiter
  import tile_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 256,
  parameter int RD_LATENCY = 1,
  localparam int GID_W     = $clog2(N_REQ)
) (
  input  logic                    out_stream_aclk,
  input  logic                    periph_resetn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    bram_en,
  output logic [ADDR_W-1:0]       bram_addr,
  input  logic [DATA_W-1:0]       bram_rdata,
  output logic [GID_W-1:0]        grant_id
);

  logic [N_REQ-1:0]  gnt;
  req_id_t           gnt_idx;
  logic              gnt_any;
  logic [ADDR_W-1:0] addr_mux;

  req_id_t rr_ptr_q, rr_ptr_d;
  tag_t    tag_q [RD_LATENCY];
  tag_t    tag_d [RD_LATENCY];
  tag_t    tag_last;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  always_comb begin
    addr_mux = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        addr_mux = req_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = next_ptr(gnt_idx, N_REQ);
    end
  end

  // Stage 0 captures this cycle's grant; later stages shift unconditionally.
  always_comb begin
    tag_d[0] = '{vld: gnt_any, id: gnt_idx};
    for (int s = 1; s < RD_LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  always_ff @(posedge out_stream_aclk) begin
    if (!periph_resetn) begin
      rr_ptr_q <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int s = 0; s < RD_LATENCY; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign tag_last = tag_q[RD_LATENCY-1];

  // Outputs are gated by reset combinationally so nothing leaks out during
  // the cycle reset is first seen, before the registers have cleared.
  always_comb begin
    rsp_valid = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rsp_valid[k] = periph_resetn && tag_last.vld && (tag_last.id == req_id_t'(k));
    end
  end

  assign rsp_data  = bram_rdata;
  assign req_ready = {N_REQ{periph_resetn}} & gnt;
  assign bram_en   = periph_resetn & gnt_any;
  assign bram_addr = periph_resetn ? addr_mux : '0;
  assign grant_id  = periph_resetn ? gnt_idx[GID_W-1:0] : '0;

endmodule

// File: tb/tb_tile_bram_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tile_bram_read_arbiter
// Four arbiter instances run side by side, each with its own directed
// stimulus and its own BRAM model:
//   inst0  N_REQ=4 RD_LATENCY=1  single requester, then rr_ptr=2 with req 0/3
//   inst1  N_REQ=4 RD_LATENCY=3  back-to-back grants 1,0
//   inst2  N_REQ=4 RD_LATENCY=2  full contention, then reset with reads in flight
//   inst3  N_REQ=3 RD_LATENCY=1  full contention, wrap at 3
// A behavioural model (round-robin scan + due-cycle response table) is
// compared every cycle; literal grant/response sequences pin the model.
// ---------------------------------------------------------------------------
module tb_tile_bram_read_arbiter;

  localparam int NI = 4;
  localparam int NCYC = 30;
  localparam int NR_T [NI] = '{4, 4, 4, 3};
  localparam int LT_T [NI] = '{1, 3, 2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn_a [NI];
  logic [3:0]   rv_a   [NI];
  logic [47:0]  ra_a   [NI];
  logic [3:0]   rdy_a  [NI];
  logic [3:0]   rsp_a  [NI];
  logic         en_a   [NI];
  logic [11:0]  addr_a [NI];
  logic [255:0] rd_a   [NI];
  logic [3:0]   gid_a  [NI];

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  int         glog [NI][40];
  logic [3:0] rlog [NI][40];

  function automatic logic [255:0] word(input logic [11:0] a);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) begin
      r[j*32 +: 32] = {a, 4'(j), 16'hC3A5} ^ (32'h01010101 * 32'(j + 1));
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [255:0] act,
                     input logic [255:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", nm, inst, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NR = (g == 3) ? 3 : 4;
    localparam int LT = (g == 1) ? 3 : ((g == 2) ? 2 : 1);

    logic [NR-1:0]         rv, rdy, rsp;
    logic [NR*12-1:0]      ra;
    logic                  en;
    logic [11:0]           addr;
    logic [255:0]          rdata, rd;
    logic [$clog2(NR)-1:0] gid;
    logic [11:0]           pa [3];
    logic                  pe [3];

    assign rv = rv_a[g][NR-1:0];
    assign ra = ra_a[g][NR*12-1:0];

    tile_bram_read_arbiter #(
      .N_REQ      (NR),
      .ADDR_W     (12),
      .DATA_W     (256),
      .RD_LATENCY (LT)
    ) u_dut (
      .out_stream_aclk (clk),
      .periph_resetn   (rstn_a[g]),
      .req_valid       (rv),
      .req_addr        (ra),
      .req_ready       (rdy),
      .rsp_valid       (rsp),
      .rsp_data        (rd),
      .bram_en         (en),
      .bram_addr       (addr),
      .bram_rdata      (rdata),
      .grant_id        (gid)
    );

    // BRAM: address sampled at an edge, word valid LT-1 edges later.
    always @(posedge clk) begin
      pa[0] <= addr;
      pe[0] <= en;
      pa[1] <= pa[0];
      pe[1] <= pe[0];
      pa[2] <= pa[1];
      pe[2] <= pe[1];
    end
    assign rdata = pe[LT-1] ? word(pa[LT-1]) : '0;

    assign rdy_a[g]  = 4'(rdy);
    assign rsp_a[g]  = 4'(rsp);
    assign en_a[g]   = en;
    assign addr_a[g] = addr;
    assign rd_a[g]   = rd;
    assign gid_a[g]  = 4'(gid);
  end

  // Behavioural model and per-cycle compare.
  initial begin
    int         m_ptr [NI];
    bit         sv    [NI][8];
    int         sid   [NI][8];
    logic [11:0] sadr [NI][8];
    int         gi, idx, slot, nxt;
    logic [3:0] e_rdy, e_rsp;
    logic       e_en;
    logic [11:0] e_addr, r_addr;
    int         e_gid;

    for (int i = 0; i < NI; i++) begin
      m_ptr[i] = 0;
      for (int s = 0; s < 8; s++) begin
        sv[i][s] = 1'b0;
        sid[i][s] = 0;
        sadr[i][s] = '0;
      end
    end

    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        gi = -1;
        e_rdy = '0;
        e_rsp = '0;
        e_en = 1'b0;
        e_addr = '0;
        e_gid = 0;
        r_addr = '0;
        slot = cyc % 8;
        if (rstn_a[i]) begin
          for (int k = 0; k < NR_T[i]; k++) begin
            idx = (m_ptr[i] + k) % NR_T[i];
            if (gi < 0 && rv_a[i][idx]) gi = idx;
          end
          if (gi >= 0) begin
            e_rdy = 4'(1) << gi;
            e_en = 1'b1;
            e_addr = ra_a[i][gi*12 +: 12];
            e_gid = gi;
          end
          if (sv[i][slot]) begin
            e_rsp = 4'(1) << sid[i][slot];
            r_addr = sadr[i][slot];
          end
        end
        chk("req_ready", i, rdy_a[i], e_rdy);
        chk("bram_en", i, en_a[i], e_en);
        chk("bram_addr", i, addr_a[i], e_addr);
        chk("grant_id", i, gid_a[i], e_gid);
        chk("rsp_valid", i, rsp_a[i], e_rsp);
        if (e_rsp != 0) chk("rsp_data", i, rd_a[i], word(r_addr));

        if (cyc < 40) begin
          glog[i][cyc] = en_a[i] ? int'(gid_a[i]) : -1;
          rlog[i][cyc] = rsp_a[i];
        end

        sv[i][slot] = 1'b0;
        if (!rstn_a[i]) begin
          m_ptr[i] = 0;
          for (int s = 0; s < 8; s++) sv[i][s] = 1'b0;
        end else if (gi >= 0) begin
          m_ptr[i] = (gi + 1) % NR_T[i];
          nxt = (cyc + LT_T[i]) % 8;
          sv[i][nxt] = 1'b1;
          sid[i][nxt] = gi;
          sadr[i][nxt] = e_addr;
        end
      end
    end
  end

  // Directed stimulus; cycle c's inputs are applied 1 ns after the edge
  // that opens it.
  initial begin
    for (int i = 0; i < NI; i++) begin
      rstn_a[i] = 1'b0;
      rv_a[i] = '0;
      ra_a[i] = '0;
    end
    for (int c = 1; c <= NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      for (int i = 0; i < NI; i++) begin
        rstn_a[i] = (c >= 2);
        rv_a[i] = '0;
        for (int r = 0; r < 4; r++) ra_a[i][r*12 +: 12] = 12'(c*16 + r*3 + i);
      end
      // inst0
      if (c >= 2 && c <= 11) begin
        rv_a[0] = 4'b0100;
        ra_a[0][2*12 +: 12] = 12'h00A;
      end
      if (c == 12) rv_a[0] = 4'b0010;
      if (c >= 13 && c <= 18) begin
        rv_a[0] = 4'b1001;
        ra_a[0][0 +: 12] = 12'h100;
        ra_a[0][3*12 +: 12] = 12'h300;
      end
      // inst1
      if (c == 2) rv_a[1] = 4'b0001;
      if (c == 3 || c == 4) begin
        rv_a[1] = 4'b0011;
        ra_a[1][0 +: 12] = 12'h020;
        ra_a[1][12 +: 12] = 12'h010;
      end
      if (c >= 10 && c <= 15) rv_a[1] = 4'b1111;
      // inst2
      if (c >= 2 && c <= 9) rv_a[2] = 4'b1111;
      if (c == 10 || c == 11) rv_a[2] = 4'b0110;
      if (c == 12) begin
        rstn_a[2] = 1'b0;
        rv_a[2] = 4'b1111;
      end
      if (c == 13) rv_a[2] = 4'b1111;
      // inst3
      if (c >= 2 && c <= 9) rv_a[3] = 4'b0111;
    end
    @(negedge clk);
    #1;

    // Hand-derived sequences.
    chk("lit0_grant_c3", 0, 256'(glog[0][3]), 256'(2));
    chk("lit0_rsp_c3", 0, rlog[0][3], 4'b0100);
    chk("lit0_grant_c13", 0, 256'(glog[0][13]), 256'(3));
    chk("lit0_grant_c14", 0, 256'(glog[0][14]), 256'(0));
    chk("lit0_grant_c15", 0, 256'(glog[0][15]), 256'(3));
    chk("lit1_grant_c3", 1, 256'(glog[1][3]), 256'(1));
    chk("lit1_grant_c4", 1, 256'(glog[1][4]), 256'(0));
    chk("lit1_rsp_c6", 1, rlog[1][6], 4'b0010);
    chk("lit1_rsp_c7", 1, rlog[1][7], 4'b0001);
    for (int c = 2; c <= 5; c++) begin
      chk("lit2_grant_seq", 2, 256'(glog[2][c]), 256'(c - 2));
    end
    chk("lit2_rsp_c4", 2, rlog[2][4], 4'b0001);
    chk("lit2_rsp_c7", 2, rlog[2][7], 4'b1000);
    chk("lit2_rsp_c12_rst", 2, rlog[2][12], 4'b0000);
    chk("lit2_rsp_c13_drop", 2, rlog[2][13], 4'b0000);
    chk("lit2_grant_c13", 2, 256'(glog[2][13]), 256'(0));
    chk("lit2_rsp_c15", 2, rlog[2][15], 4'b0001);
    chk("lit3_grant_c2", 3, 256'(glog[3][2]), 256'(0));
    chk("lit3_grant_c3", 3, 256'(glog[3][3]), 256'(1));
    chk("lit3_grant_c4", 3, 256'(glog[3][4]), 256'(2));
    chk("lit3_grant_c5", 3, 256'(glog[3][5]), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
